// File: rtl/voice_alloc_pkg.sv
// Shared constants and types for the polyphonic voice allocator.
package voice_alloc_pkg;
  localparam int MIDI_PAYLOAD_BITS  = 7;
  localparam int VOICE_IDX_BITS     = 3;
  localparam int NUM_VOICES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_RETRIG = 2'd1,
    ACT_ASSIGN = 2'd2,
    ACT_DROP   = 2'd3
  } alloc_act_t;
endpackage

// File: rtl/voice_lru.sv
// Age tracker for voice slots: ages form a permutation, 0 = most recently touched.
module voice_lru #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        touch,
  input  logic [IDX_W-1:0]            touch_idx,
  output logic [IDX_W-1:0]            oldest_idx,
  output logic [NUM_VOICES*IDX_W-1:0] age_vec
);
  logic [IDX_W-1:0] age_reg [NUM_VOICES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_VOICES; v++) age_reg[v] <= IDX_W'(v);
    end else if (touch) begin
      // Only voices younger than the touched one age; the permutation is preserved.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == touch_idx)
          age_reg[v] <= '0;
        else if (age_reg[v] < age_reg[touch_idx])
          age_reg[v] <= age_reg[v] + 1'b1;
      end
    end
  end

  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (age_reg[v] == IDX_W'(NUM_VOICES - 1)) oldest_idx = IDX_W'(v);
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_age
      assign age_vec[gi*IDX_W +: IDX_W] = age_reg[gi];
    end
  endgenerate
endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: retrigger, lowest free slot, else steal oldest
// (VOICE_STEAL_EN defined) or drop the note-on (VOICE_STEAL_EN undefined).
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [MIDI_PAYLOAD_BITS-1:0]           note_i,
  input  logic                                   noteOnStrb_i,
  input  logic                                   noteOffStrb_i,
  output logic [NUM_VOICES*MIDI_PAYLOAD_BITS-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]                  voiceActive_o,
  output logic [NUM_VOICES-1:0]                  voiceTrig_o,
  output logic                                   dropStrb_o
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int W     = MIDI_PAYLOAD_BITS;

  logic [W-1:0]            note_reg [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_reg;
  logic [NUM_VOICES-1:0]   trig_reg;
  logic [NUM_VOICES-1:0]   match;
  logic [NUM_VOICES-1:0]   free;
  logic [IDX_W-1:0]        match_idx;
  logic [IDX_W-1:0]        free_idx;
  logic [IDX_W-1:0]        oldest_idx;
  logic [IDX_W-1:0]        tgt_idx;
  logic [NUM_VOICES*IDX_W-1:0] age_vec;
  logic                    touch;
  alloc_act_t              act;

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign match[gi] = active_reg[gi] && (note_reg[gi] == note_i);
      assign free[gi]  = ~active_reg[gi];
      assign voiceNote_o[gi*W +: W] = note_reg[gi];
    end
  endgenerate

  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (match[v]) match_idx = IDX_W'(v);
      if (free[v])  free_idx  = IDX_W'(v);
    end
  end

  always_comb begin
    act     = ACT_NONE;
    tgt_idx = '0;
    if (noteOnStrb_i) begin
      if (|match) begin
        act     = ACT_RETRIG;
        tgt_idx = match_idx;
      end else if (|free) begin
        act     = ACT_ASSIGN;
        tgt_idx = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        act     = ACT_ASSIGN;
        tgt_idx = oldest_idx;
`else
        act     = ACT_DROP;
`endif
      end
    end
  end

  assign touch = (act == ACT_RETRIG) || (act == ACT_ASSIGN);

  voice_lru #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_lru (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .touch      (touch),
    .touch_idx  (tgt_idx),
    .oldest_idx (oldest_idx),
    .age_vec    (age_vec)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_VOICES; v++) note_reg[v] <= '0;
      active_reg <= '0;
      trig_reg   <= '0;
    end else begin
      trig_reg <= '0;
      if (touch) begin
        note_reg[tgt_idx]   <= note_i;
        active_reg[tgt_idx] <= 1'b1;
        trig_reg[tgt_idx]   <= 1'b1;
      end else if (!noteOnStrb_i && noteOffStrb_i && (|match)) begin
        // The note register is kept so the release phase retains its pitch.
        active_reg[match_idx] <= 1'b0;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  assign dropStrb_o = 1'b0;
`else
  logic drop_reg;
  logic unused_oldest;
  assign unused_oldest = ^oldest_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_reg <= 1'b0;
    else       drop_reg <= (act == ACT_DROP);
  end
  assign dropStrb_o = drop_reg;
`endif

  logic unused_age;
  assign unused_age = ^age_vec;

  assign voiceActive_o = active_reg;
  assign voiceTrig_o   = trig_reg;
endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator between the MIDI parser and the oscillator bank. It consumes the parser's note-on and note-off strobes and assigns each sounding note to one of `NUM_VOICES` voice slots. When all slots are busy it steals the least-recently-assigned slot. Per-voice outputs (note number, gate, retrigger pulse) drive the per-voice oscillator and envelope datapaths.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of voice slots; power of two, 2..8.

Ports:
- `clk_i`  input  1  system clock. One clock domain; reset is synchronous and active-high.
- `rst_i`  input  1  synchronous active-high reset.
- `note_i`  input  `MIDI_PAYLOAD_BITS`  note number; valid only in a strobe cycle.
- `noteOnStrb_i`  input  1  one-cycle note-on request.
- `noteOffStrb_i`  input  1  one-cycle note-off request.
- `voiceNote_o`  output  `NUM_VOICES*MIDI_PAYLOAD_BITS`  note number per voice; voice v occupies bits `[v*W +: W]`.
- `voiceActive_o`  output  `NUM_VOICES`  gate per voice.
- `voiceTrig_o`  output  `NUM_VOICES`  one-cycle pulse when a voice is assigned or retriggered.
- `dropStrb_o`  output  1  one-cycle pulse when a note-on is discarded.

## Operation
- Per-voice state: note register, active flag, age (log2(NUM_VOICES) bits).
- Ages always form a permutation of 0..NUM_VOICES-1. Age 0 is the most recently assigned voice; age NUM_VOICES-1 is the oldest.
- Note-on with note N, evaluated in priority order:
  1. N is already held by an active voice k: retrigger k. Note unchanged, active stays 1, trig[k] pulses, k becomes age 0.
  2. Otherwise, at least one inactive voice exists: choose the lowest-index inactive voice k.
  3. Otherwise (all voices active): steal the voice with age NUM_VOICES-1. Behaviour depends on `VOICE_STEAL_EN` (see Configuration).
- Assigning voice k (cases 2 and 3): note[k] <= N, active[k] <= 1, trig[k] pulses.
- Age update on any assignment or retrigger of voice k:
  - Every voice j with age[j] < age[k] increments its age.
  - age[k] <= 0.
  - All other ages are unchanged.
- Note-off with note N:
  - Clears active[k] for the active voice holding N.
  - The note register is retained so the release phase keeps its pitch.
  - Ages are unchanged. No trig pulse.
- Note-off for a note not held by any active voice is ignored.
- Invariant: at most one active voice holds a given note, guaranteed by the retrigger rule.
- If both strobes are asserted in the same cycle, note-on wins and note-off is ignored. The parser never does this.
- Strobes arriving in back-to-back cycles are each fully processed. There is no busy state.

## Timing
- All outputs are registered. Latency is 1 cycle: a strobe in cycle t updates the outputs visible in cycle t+1.
- `voiceTrig_o` and `dropStrb_o` are high for exactly one cycle, in t+1.
- Reset values:
  - voiceNote_o = 0, voiceActive_o = 0, voiceTrig_o = 0, dropStrb_o = 0.
  - age[v] = v, so voice NUM_VOICES-1 is the oldest.
- Reset asserted mid-operation overrides any strobe in the same cycle. The state returns to the reset values at the next edge.
- The allocation decision is combinational from the current registered state, to meet the 1-cycle latency. The priority encoder and the age compare are both on the same path.

## Configuration
- `VOICE_STEAL_EN` defined:
  - A note-on with all voices active steals the oldest voice.
  - Its note is overwritten and trig pulses.
  - `dropStrb_o` is tied to 0.
- `VOICE_STEAL_EN` undefined:
  - A note-on with all voices active (and no retrigger match) is discarded.
  - `dropStrb_o` pulses; no voice state or age changes.
- The port list is identical in both builds.

## Structure
- Add to `global.v`: `VOICE_IDX_BITS` (log2 of the maximum voice count, 3) and the default voice count `NUM_VOICES_DEFAULT` (4).
- `MIDI_PAYLOAD_BITS` is reused from `global.v`.
- One sub-module, `voice_lru`:
  - Holds the age registers.
  - Inputs: touch strobe and touch index.
  - Outputs: oldest-voice index and the age vector.
- `voice_alloc` keeps the note/active registers, the match and free-slot priority encoders, and the output pulses.

## Test plan
- After reset, note-on 60, 62, 64 (NUM_VOICES=4) -> voices 0, 1, 2 get notes 60/62/64. trig pulses on 0, 1, 2 one cycle after each strobe. voiceActive_o = 4'b0111.
- With 60 on voice 0, note-on 60 again -> trig[0] pulses, no other voice changes, age[0] = 0.
- Voices 0-3 hold 60, 62, 64, 65 (assigned in that order); note-on 67 with `VOICE_STEAL_EN` -> voice 0 becomes 67, trig[0] pulses. Without the macro -> dropStrb_o pulses and the voices are unchanged.
- Note-off 62 with 62 on voice 1 -> active[1] = 0, voiceNote[1] stays 62. Then note-on 70 -> voice 1 gets 70.
- Note-off 99 (not held) -> no output change. Both strobes asserted with note 64 (held) -> treated as note-on retrigger, voice stays active.
- Assert `rst_i` in the same cycle as a note-on -> next cycle all outputs are 0 and ages are 0, 1, 2, 3.
